// File: rtl/euler_pkg.sv
// Shared types and Q8.8 constants for the Euler step unit and its multiplier.
package euler_pkg;

    localparam int WIDTH      = 16;
    localparam int FRAC       = 8;
    localparam int MULT_ITERS = 16;

    localparam logic [WIDTH-1:0] SAT_POS = 16'h7FFF;
    localparam logic [WIDTH-1:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    // 17-bit magnitude so that -32768 maps to an exact +32768.
    function automatic logic [WIDTH:0] mag17(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? {1'b0, ~v + 16'd1} : {1'b0, v};
    endfunction

endpackage

// File: rtl/seq_mult_16.sv
// Radix-2 shift-add magnitude multiplier: one multiplier bit per cycle into a 34-bit accumulator.
module seq_mult_16
    import euler_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH:0]       a,
    input  logic [WIDTH:0]       b,
    output logic                 done,
    output logic [2*WIDTH+1:0]   product
);

    // Handshake: start loads a/b and begins 16 iterations; done is high during the
    // final iteration and product is valid from the following cycle until the next start.
    logic [2*WIDTH+1:0] acc;
    logic [2*WIDTH+1:0] mcand;
    logic [WIDTH:0]     mplier;
    logic [3:0]         cnt;
    logic               busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{(WIDTH+1){1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 4'd1;
            if (cnt == 4'(MULT_ITERS - 1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign done    = busy && (cnt == 4'(MULT_ITERS - 1));
    assign product = acc;

endmodule

// File: rtl/euler_step_unit.sv
// Sequential Q8.8 Euler update x_out = x_in + h*f with saturated multiply and add.
module euler_step_unit
    import euler_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] h_in,
    input  logic [WIDTH-1:0] f_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] x_out,
    output logic             overflow,
    output state_t           fsm_state
);

    state_t             state_q, state_d;
    logic               accept;
    logic [WIDTH-1:0]   x_q;
    logic               sign_q;
    logic               mult_done;
    logic [2*WIDTH+1:0] product;
    logic [2*WIDTH+1:0] scaled;
    logic [WIDTH-1:0]   p;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   result;
    logic               mul_ovf;
    logic               add_ovf;

    assign ready     = (state_q == IDLE);
    assign accept    = start && ready;
    assign fsm_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = MULT;
            MULT:    if (mult_done) state_d = ADD;
            ADD:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    seq_mult_16 u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept),
        .a       (mag17(h_in)),
        .b       (mag17(f_in)),
        .done    (mult_done),
        .product (product)
    );

    // Magnitude shift truncates toward zero before the sign is applied.
    assign scaled = product >> FRAC;

    always_comb begin
        p       = scaled[WIDTH-1:0];
        mul_ovf = 1'b0;
        if (!sign_q) begin
            if (scaled > 34'd32767) begin
                p       = SAT_POS;
                mul_ovf = 1'b1;
            end
        end else if (scaled > 34'd32768) begin
            p       = SAT_NEG;
            mul_ovf = 1'b1;
        end else begin
            p = ~scaled[WIDTH-1:0] + 16'd1;
        end
    end

    always_comb begin
        sum     = x_q + p;
        add_ovf = (x_q[WIDTH-1] == p[WIDTH-1]) && (sum[WIDTH-1] != x_q[WIDTH-1]);
        result  = add_ovf ? (x_q[WIDTH-1] ? SAT_NEG : SAT_POS) : sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            sign_q   <= 1'b0;
            done     <= 1'b0;
            x_out    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                x_q    <= x_in;
                sign_q <= h_in[WIDTH-1] ^ f_in[WIDTH-1];
            end
            done <= (state_q == ADD);
            if (state_q == ADD) begin
                x_out    <= result;
                overflow <= mul_ovf | add_ovf;
            end
        end
    end

endmodule

// File: tb/tb_euler_step_unit.sv
// Bench for euler_step_unit: integer reference model, per-cycle compare process, directed vectors.
module tb_euler_step_unit;
    import euler_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] x_in;
    logic [15:0] h_in;
    logic [15:0] f_in;
    logic        ready;
    logic        done;
    logic [15:0] x_out;
    logic        overflow;
    state_t      fsm_state;

    int n_cmp    = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int ready_at = 0;
    int done_at  = -1;

    logic [15:0] hold_x   = '0;
    logic        hold_ovf = 1'b0;
    logic [16:0] exp_q[$];

    euler_step_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x_in      (x_in),
        .h_in      (h_in),
        .f_in      (f_in),
        .ready     (ready),
        .done      (done),
        .x_out     (x_out),
        .overflow  (overflow),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Reference: exact signed product, divide truncates toward zero, clamp, add, clamp.
    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] h,
                                          input logic [15:0] f);
        longint prod;
        longint q;
        longint s;
        logic   o;
        o    = 1'b0;
        prod = longint'($signed(h)) * longint'($signed(f));
        q    = prod / 256;
        if (q > 32767) begin
            q = 32767;
            o = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            o = 1'b1;
        end
        s = longint'($signed(x)) + q;
        if (s > 32767) begin
            s = 32767;
            o = 1'b1;
        end else if (s < -32768) begin
            s = -32768;
            o = 1'b1;
        end
        return {o, s[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // scoreboard / compare process
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst_n) begin
            ready_at = 0;
            done_at  = -1;
            exp_q.delete();
            hold_x   = '0;
            hold_ovf = 1'b0;
            check("reset_ready", 32'(ready), 32'd1);
            check("reset_done", 32'(done), 32'd0);
            check("reset_x_out", 32'(x_out), 32'd0);
            check("reset_overflow", 32'(overflow), 32'd0);
            check("reset_state_idle", 32'(fsm_state == IDLE), 32'd1);
        end else begin
            check("ready", 32'(ready), 32'(cyc >= ready_at));
            if (cyc == done_at) begin
                check("done_pulse", 32'(done), 32'd1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL exp_q_underflow: got empty queue, required one entry");
                end else begin
                    e        = exp_q.pop_front();
                    hold_x   = e[15:0];
                    hold_ovf = e[16];
                end
            end else begin
                check("done_quiet", 32'(done), 32'd0);
            end
            check("x_out", 32'(x_out), 32'(hold_x));
            check("overflow", 32'(overflow), 32'(hold_ovf));
            if (start && cyc >= ready_at) begin
                exp_q.push_back(model(x_in, h_in, f_in));
                done_at  = cyc + 1 + 17;
                ready_at = cyc + 1 + 18;
            end
        end
    end

    // driver: one operation with literal expected result; optional start noise while busy
    task automatic run_op(input string name, input logic [15:0] x, input logic [15:0] h,
                          input logic [15:0] f, input logic [15:0] ex, input logic eo,
                          input bit noise);
        bit got;
        int lat;
        got = 1'b0;
        lat = -1;
        @(posedge clk); #1;
        x_in  = x;
        h_in  = h;
        f_in  = f;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                lat = i;
                break;
            end
            if (noise && (i % 4 == 1)) begin
                #1;
                start = 1'b1;
                x_in  = 16'h7000;
                h_in  = 16'h7FFF;
                f_in  = 16'h7FFF;
            end else if (noise) begin
                #1;
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no done in 40 cycles, required done", name);
        end else begin
            check({name, "_latency"}, 32'(lat), 32'd17);
            check({name, "_x_out"}, 32'(x_out), 32'(ex));
            check({name, "_overflow"}, 32'(overflow), 32'(eo));
        end
    endtask

    initial begin
        int n_done;
        start = 1'b0;
        x_in  = '0;
        h_in  = '0;
        f_in  = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // pin the reference model to hand-computed values
        check("model_basic", 32'(model(16'h0100, 16'h0080, 16'h0400)), 32'h00300);
        check("model_mulsat", 32'(model(16'h0000, 16'h7FFF, 16'h7FFF)), 32'h17FFF);
        check("model_minval", 32'(model(16'h0000, 16'h8000, 16'h0100)), 32'h08000);
        check("model_trunc", 32'(model(16'h1234, 16'h0001, 16'hFFFF)), 32'h01234);
        check("model_negtrunc", 32'(model(16'h0000, 16'h0003, 16'hFF80)), 32'h0FFFF);

        run_op("basic",     16'h0100, 16'h0080, 16'h0400, 16'h0300, 1'b0, 1'b0);
        run_op("negative",  16'h0100, 16'h0080, 16'hFC00, 16'hFF00, 1'b0, 1'b0);
        run_op("add_sat",   16'h7F00, 16'h0100, 16'h0200, 16'h7FFF, 1'b1, 1'b0);
        run_op("mul_sat",   16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
        run_op("min_value", 16'h0000, 16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0);
        run_op("trunc",     16'h1234, 16'h0001, 16'hFFFF, 16'h1234, 1'b0, 1'b0);
        run_op("neg_add",   16'h8100, 16'hFF00, 16'h0200, 16'h8000, 1'b1, 1'b0);
        run_op("neg_mul",   16'h0000, 16'h8000, 16'h0200, 16'h8000, 1'b1, 1'b0);
        run_op("neg_trunc", 16'h0000, 16'h0003, 16'hFF80, 16'hFFFF, 1'b0, 1'b0);
        run_op("noise",     16'h0010, 16'hFF80, 16'hFF00, 16'h0090, 1'b0, 1'b1);

        // start held high through DONE: second op accepted at the first IDLE edge
        @(posedge clk); #1;
        x_in  = 16'h0200;
        h_in  = 16'h0100;
        f_in  = 16'h0100;
        start = 1'b1;
        repeat (20) @(posedge clk);
        #1 start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("held_second_done", 32'(n_done), 32'd1);
        check("held_x_out", 32'(x_out), 32'h0300);

        // reset in the middle of MULT abandons the operation
        @(posedge clk); #1;
        x_in  = 16'h0100;
        h_in  = 16'h0080;
        f_in  = 16'h0400;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        check("abort_x_out", 32'(x_out), 32'd0);

        run_op("after_reset", 16'h0100, 16'h0080, 16'h0400, 16'h0300, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
